fp32_to_fixed_pipe: RTL and testbench
=====================================

Name: fp32_to_fixed_pipe

Overview:
- Pipelined, parametrised successor to the combinational float-to-int16 converter.
- Computes out = clamp(round((in + OFFSET) * 2^FRAC_W)) for IEEE-754 single-precision input.
- Scaling is a power of two, applied as an exponent shift rather than an FP multiplier. Offset is added in the fixed-point domain rather than through an FP adder.
- Sits between the NN datapath's float results and the integer activation/storage stages. Valid/ready on both sides, full-throughput backpressure.

Parameters:
- OUT_W, 16, output width in bits (4..32).
- FRAC_W, 5, power-of-two scale exponent (0..OUT_W).
- OFFSET, 1024, signed integer added before scaling. Constraint: |OFFSET|*2^FRAC_W < 2^(OUT_W+5).
- SIGNED_OUT, 0. 0 = clamp to [0, 2^OUT_W-1]; 1 = two's complement clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept input this cycle.
- in_data  in  32  IEEE-754 single.
- rnd_mode  in  1  0 = truncate toward -inf (floor), 1 = round-half-to-even. Sampled with in_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  converted value.
- out_ovf  out  1  clamped at the upper limit (includes +inf).
- out_unf  out  1  clamped at the lower limit (includes -inf).
- out_nan  out  1  input was NaN.

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, out_valid=0, out_data=0, all flags 0. in_ready goes to 1 on the first cycle after reset release. Reset mid-operation discards every in-flight word.
- Transfers:
  - Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_data and flags stay stable while out_valid && !out_ready.
- Pipeline: three stages S1..S3, each with a valid bit.
  - Stage k loads when it is empty or stage k+1 loads in the same cycle.
  - S3 advances when out_ready or !out_valid.
  - in_ready = !v1 || S1 advances (combinational from out_ready through the chain).
  - Latency is 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 word/cycle.
- S1, decode and classify:
  - Split sign/exp/mantissa. e = exp-127.
  - Class NAN: exp=255, mant≠0. Class INF: exp=255, mant=0. Class ZERO: exp=0; denormals are flushed to zero. Otherwise NORM.
  - Shift amount sh = e + FRAC_W - 23.
  - BIG is set if e + FRAC_W ≥ OUT_W+6.
- S2, shift and round:
  - Operand is the 24-bit significand {1,mant}.
  - sh ≥ 0: shift left into a signed internal word of IW = OUT_W+8 bits.
  - sh < 0: shift right. Compute guard bit and sticky (OR of all lower bits).
    - Floor mode on a negative input with any discarded bit set: magnitude +1.
    - RNE mode: increment when guard && (sticky || lsb).
  - Apply sign after rounding.
  - sh ≤ -25 gives a zero magnitude, with floor still applied to negative inputs (→ -1).
- S3, offset and clamp:
  - Compute sum = value + (OFFSET << FRAC_W) in IW bits.
  - Clamp to the range set by SIGNED_OUT.
  - Upper clamp sets out_ovf; lower clamp sets out_unf. Exact equality to a limit sets no flag.
- Special classes bypass the arithmetic:
  - INF or BIG: saturate per sign, with the matching flag.
  - ZERO: value 0; offset still applies.
  - NAN: out_data=0, out_nan=1, out_ovf=out_unf=0.
- At most one of the three flags is 1. No $display or simulation-only output in RTL.

Decomposition:
- Shared package fp_pkg holds:
  - FP32 field localparams: EXP_BIAS=127, MANT_W=23, EXP_MAX=255.
  - A class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
  - A stage payload struct: class, sign, sh, rnd_mode.
- One natural sub-module, fp_shift_round: the combinational S2 shifter with guard/sticky and rounding, reusable by future fixed-to-float work.
- The top module holds the handshake, stage registers and clamp logic.

Test Plan:
- Defaults, rnd_mode=0. Expected out_data:
  - 0x00000000 (0.0) → 0x8000.
  - 0x3FC00000 (1.5) → 0x8030.
  - 0xC4800000 (-1024.0) → 0x0000, no flag.
  - 0x44800000 (1024.0) → 0xFFFF with out_ovf.
  - 0xC4FA0000 (-2000.0) → 0x0000 with out_unf.
- Rounding:
  - 0x3D400000 (0.046875 → 32769.5): rnd_mode=0 gives 0x8001; rnd_mode=1 gives 0x8002.
  - 0x3C800000 (0.015625 → 32768.5): rnd_mode=1 gives 0x8000 (half to even).
- Specials:
  - 0x7FC00000 → 0x0000 with out_nan.
  - 0xFF800000 → 0x0000 with out_unf.
  - 0x00000001 (denormal) → 0x8000.
  - 0x7F000000 (BIG) → 0xFFFF with out_ovf.
- Backpressure:
  - Stream 8 words back-to-back while holding out_ready=0 for cycles 4..9.
  - in_ready must drop once S1..S3 are full.
  - All 8 results emerge in order, none lost or duplicated, and out_data stays stable while stalled.
  - With out_ready=1 throughout, 1 word/cycle at 3-cycle latency.
- Reset mid-stream:
  - Assert rst_n=0 asynchronously with 3 words in flight: out_valid drops immediately.
  - After release, no stale word appears, and the next input emerges 3 cycles after its transfer.
- SIGNED_OUT=1, OFFSET=0, FRAC_W=5:
  - -1.5 → 0xFFD0.
  - 2000.0 → 0x7FFF with out_ovf.
  - -2000.0 → 0x8000 with out_unf.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for float/fixed conversion blocks.
// Holds IEEE-754 single field constants, the input class enum and the
// decoded-stage payload passed from decode to the shift/round stage.
package fp_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned EXP_MAX  = 255;
    localparam int unsigned EXP_W    = 8;
    // Signed shift-amount width; covers e + FRAC_W - 23 for every exponent.
    localparam int unsigned SH_W     = 10;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Decoded word: class, sign, shift amount, rounding mode, plus the
    // mantissa and the early overflow indication for the next stage.
    typedef struct packed {
        fp_class_e         cls;
        logic              sign;
        logic [SH_W-1:0]   sh;
        logic              rnd_mode;
        logic              big;
        logic [MANT_W-1:0] mant;
    } fp_stage_t;

    // Classify from raw fields; denormals are treated as zero.
    function automatic fp_class_e fp_classify(input logic [EXP_W-1:0] exp_f,
                                              input logic [MANT_W-1:0] mant);
        fp_class_e c;
        if (exp_f == EXP_W'(EXP_MAX)) begin
            c = (mant != '0) ? FP_NAN : FP_INF;
        end else if (exp_f == '0) begin
            c = FP_ZERO;
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_shift_round.sv
// Combinational significand shifter with guard/sticky rounding.
// Ports: mant   - 23-bit mantissa (hidden 1 added here)
//        sh     - signed shift (>=0 left, <0 right)
//        sign   - input sign, applied after rounding
//        rnd_mode - 0 floor, 1 round-half-to-even
//        value  - signed IW-bit result
module fp_shift_round
    import fp_pkg::*;
#(
    parameter int unsigned IW = 24
) (
    input  logic [MANT_W-1:0]     mant,
    input  logic signed [SH_W-1:0] sh,
    input  logic                  sign,
    input  logic                  rnd_mode,
    output logic signed [IW-1:0]  value
);

    localparam int unsigned SIG_W = MANT_W + 1;
    localparam int unsigned EXT_W = 2 * SIG_W;

    logic [SIG_W-1:0] sig;
    logic [SH_W-1:0]  nsh;
    logic [5:0]       rs;
    logic [EXT_W-1:0] ext;
    logic [SIG_W-1:0] q;
    logic             guard;
    logic             sticky;
    logic             inc;
    logic [63:0]      mag;

    always_comb begin
        sig = {1'b1, mant};
        nsh = SH_W'(-sh);
        // Clamp right shifts past the extended word; the result is zero anyway.
        rs  = (nsh >= SH_W'(EXT_W)) ? 6'(EXT_W) : nsh[5:0];
        // Low half of ext receives the discarded bits: [SIG_W-1] is guard.
        ext = {sig, SIG_W'(0)} >> rs;
        q      = ext[EXT_W-1:SIG_W];
        guard  = ext[SIG_W-1];
        // Beyond a full significand shift the hidden 1 is always lost below guard.
        sticky = (nsh > SH_W'(SIG_W)) ? 1'b1 : (|ext[SIG_W-2:0]);
        // Floor on magnitude means round away from zero for negatives.
        inc = rnd_mode ? (guard & (sticky | q[0])) : (sign & (guard | sticky));
        if (sh >= 0) begin
            mag = 64'(sig) << sh[5:0];
        end else begin
            mag = 64'(q) + 64'(inc);
        end
        value = sign ? IW'(-mag) : IW'(mag);
    end

endmodule

// File: rtl/fp32_to_fixed_pipe.sv
// Three-stage FP32 to fixed-point converter with valid/ready handshake.
// out = clamp(round((in + OFFSET) * 2^FRAC_W)).
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready/in_data/rnd_mode - input word and rounding mode
//        out_valid/out_ready/out_data       - converted value
//        out_ovf/out_unf/out_nan            - upper clamp / lower clamp / NaN
module fp32_to_fixed_pipe
    import fp_pkg::*;
#(
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FRAC_W     = 5,
    parameter int          OFFSET     = 1024,
    parameter bit          SIGNED_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             rnd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_nan
);

    localparam int unsigned IW = OUT_W + 8;

    localparam longint OFF_L = longint'(OFFSET) * (longint'(1) <<< FRAC_W);
    localparam longint MAX_L = SIGNED_OUT ? ((longint'(1) <<< (OUT_W - 1)) - 1)
                                          : ((longint'(1) <<< OUT_W) - 1);
    localparam longint MIN_L = SIGNED_OUT ? -(longint'(1) <<< (OUT_W - 1)) : longint'(0);

    localparam logic signed [IW-1:0]   OFF_SC = IW'(OFF_L);
    localparam logic signed [IW-1:0]   MAX_SC = IW'(MAX_L);
    localparam logic signed [IW-1:0]   MIN_SC = IW'(MIN_L);
    localparam logic signed [SH_W-1:0] SH_ADJ = SH_W'(int'(FRAC_W) - int'(MANT_W));
    localparam logic signed [SH_W-1:0] BIG_TH = SH_W'(int'(OUT_W) + 6 - int'(FRAC_W));

    // Handshake chain: each stage loads when empty or when its successor loads.
    logic ld1, ld2, ld3;
    logic v1, v2;

    assign ld3       = !out_valid || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;

    // S1 decode.
    fp_stage_t              dec;
    logic signed [SH_W-1:0] e_s;

    always_comb begin
        dec          = '0;
        dec.sign     = in_data[31];
        dec.mant     = in_data[MANT_W-1:0];
        dec.rnd_mode = rnd_mode;
        dec.cls      = fp_classify(in_data[30:23], in_data[MANT_W-1:0]);
        e_s          = $signed({2'b00, in_data[30:23]}) - $signed(SH_W'(EXP_BIAS));
        dec.sh       = e_s + SH_ADJ;
        dec.big      = (e_s >= BIG_TH);
    end

    fp_stage_t s1;

    // S2 shift and round.
    logic signed [IW-1:0] sr_value;

    fp_shift_round #(.IW(IW)) u_shift_round (
        .mant     (s1.mant),
        .sh       ($signed(s1.sh)),
        .sign     (s1.sign),
        .rnd_mode (s1.rnd_mode),
        .value    (sr_value)
    );

    fp_class_e            s2_cls;
    logic                 s2_sign;
    logic                 s2_big;
    logic signed [IW-1:0] s2_val;

    // S3 offset, clamp and special-class bypass.
    logic signed [IW-1:0] sum;
    logic [OUT_W-1:0]     d_data;
    logic                 d_ovf, d_unf, d_nan;
    logic                 sat;

    always_comb begin
        d_data = '0;
        d_ovf  = 1'b0;
        d_unf  = 1'b0;
        d_nan  = 1'b0;
        sum    = s2_val + OFF_SC;
        sat    = (s2_cls == FP_INF) || (s2_cls == FP_NORM && s2_big);
        if (s2_cls == FP_NAN) begin
            d_nan = 1'b1;
        end else if (sat) begin
            if (s2_sign) begin
                d_data = OUT_W'(MIN_SC);
                d_unf  = 1'b1;
            end else begin
                d_data = OUT_W'(MAX_SC);
                d_ovf  = 1'b1;
            end
        end else if (sum > MAX_SC) begin
            d_data = OUT_W'(MAX_SC);
            d_ovf  = 1'b1;
        end else if (sum < MIN_SC) begin
            d_data = OUT_W'(MIN_SC);
            d_unf  = 1'b1;
        end else begin
            d_data = sum[OUT_W-1:0];
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            s1        <= '0;
            s2_cls    <= FP_ZERO;
            s2_sign   <= 1'b0;
            s2_big    <= 1'b0;
            s2_val    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_nan   <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1 <= dec;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    s2_cls  <= s1.cls;
                    s2_sign <= s1.sign;
                    s2_big  <= s1.big;
                    s2_val  <= (s1.cls == FP_ZERO) ? '0 : sr_value;
                end
            end
            if (ld3) begin
                out_valid <= v2;
                if (v2) begin
                    out_data <= d_data;
                    out_ovf  <= d_ovf;
                    out_unf  <= d_unf;
                    out_nan  <= d_nan;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp32_to_fixed_pipe.sv
module tb_fp32_to_fixed_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data = 32'h0;

    logic        in_ready, out_valid, out_ovf, out_unf, out_nan;
    logic [15:0] out_data;
    logic        in_ready_s, out_valid_s, out_ovf_s, out_unf_s, out_nan_s;
    logic [15:0] out_data_s;

    always #5 clk = ~clk;

    fp32_to_fixed_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
        .out_unf(out_unf), .out_nan(out_nan)
    );

    fp32_to_fixed_pipe #(.OUT_W(16), .FRAC_W(5), .OFFSET(0), .SIGNED_OUT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .rnd_mode(rnd_mode), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_ovf(out_ovf_s),
        .out_unf(out_unf_s), .out_nan(out_nan_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] r_data, r_sdata;
    logic [2:0]  r_flags, r_sflags;
    int          r_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One word through both converters; captures results and latency.
    task automatic convert(input logic [31:0] d, input logic rnd);
        int w;
        r_lat    = -1;
        r_data   = 'x;
        r_sdata  = 'x;
        r_flags  = 'x;
        r_sflags = 'x;
        in_data  = d;
        rnd_mode = rnd;
        out_ready = 1'b1;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                r_lat   = i + 1;
                r_data  = out_data;
                r_flags = {out_nan, out_ovf, out_unf};
                if (out_valid_s) begin
                    r_sdata  = out_data_s;
                    r_sflags = {out_nan_s, out_ovf_s, out_unf_s};
                end
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] bp_word [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [15:0] bp_exp [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx, nout, in_cyc [4], out_cyc [4];
        logic        saw_block, held_valid, stale;
        logic [15:0] held_data;
        logic [15:0] tp_data [4];

        for (int k = 0; k < 8; k++) bp_exp[k] = 16'h8000 + 16'(32 * (k + 1));

        // Reset state.
        #3;
        check("rst_state", 32'({out_valid, out_nan, out_ovf, out_unf}), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'({in_ready, in_ready_s}), 32'h3);

        // Default parameters, floor rounding.
        convert(32'h00000000, 1'b0);
        check("zero_lat", 32'(r_lat), 32'd3);
        check("zero", 32'(r_data), 32'h8000);
        check("zero_flags", 32'(r_flags), 32'h0);
        convert(32'h3FC00000, 1'b0);
        check("p1_5", 32'(r_data), 32'h8030);
        check("p1_5_flags", 32'(r_flags), 32'h0);
        convert(32'hC4800000, 1'b0);
        check("m1024", 32'(r_data), 32'h0000);
        check("m1024_flags", 32'(r_flags), 32'h0);
        convert(32'h44800000, 1'b0);
        check("p1024", 32'(r_data), 32'hFFFF);
        check("p1024_flags", 32'(r_flags), 32'h2);
        convert(32'hC4FA0000, 1'b0);
        check("m2000", 32'(r_data), 32'h0000);
        check("m2000_flags", 32'(r_flags), 32'h1);

        // Rounding modes.
        convert(32'h3D400000, 1'b0);
        check("rnd_floor", 32'(r_data), 32'h8001);
        convert(32'h3D400000, 1'b1);
        check("rnd_rne_up", 32'(r_data), 32'h8002);
        convert(32'h3C800000, 1'b1);
        check("rnd_rne_even", 32'(r_data), 32'h8000);

        // Special classes.
        convert(32'h7FC00000, 1'b0);
        check("nan", 32'(r_data), 32'h0000);
        check("nan_flags", 32'(r_flags), 32'h4);
        convert(32'hFF800000, 1'b0);
        check("ninf", 32'(r_data), 32'h0000);
        check("ninf_flags", 32'(r_flags), 32'h1);
        convert(32'h00000001, 1'b0);
        check("denorm", 32'(r_data), 32'h8000);
        check("denorm_flags", 32'(r_flags), 32'h0);
        convert(32'h7F000000, 1'b0);
        check("big", 32'(r_data), 32'hFFFF);
        check("big_flags", 32'(r_flags), 32'h2);

        // Signed output, zero offset.
        convert(32'hBFC00000, 1'b0);
        check("s_m1_5", 32'(r_sdata), 32'hFFD0);
        check("s_m1_5_flags", 32'(r_sflags), 32'h0);
        convert(32'h44FA0000, 1'b0);
        check("s_p2000", 32'(r_sdata), 32'h7FFF);
        check("s_p2000_flags", 32'(r_sflags), 32'h2);
        convert(32'hC4FA0000, 1'b0);
        check("s_m2000", 32'(r_sdata), 32'h8000);
        check("s_m2000_flags", 32'(r_sflags), 32'h1);
        @(posedge clk); #1;

        // Backpressure: 8 words, out_ready low in cycles 4..9.
        idx = 0; nout = 0; saw_block = 1'b0; held_valid = 1'b0; held_data = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid  = (idx < 8);
            in_data   = (idx < 8) ? bp_word[idx] : 32'h0;
            rnd_mode  = 1'b0;
            out_ready = !(cyc >= 4 && cyc <= 9);
            #1;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (held_valid) begin
                check("bp_hold_valid", 32'(out_valid), 32'h1);
                check("bp_stable", 32'(out_data), 32'(held_data));
            end
            if (out_valid && out_ready) begin
                if (nout < 8) check("bp_data", 32'(out_data), 32'(bp_exp[nout]));
                nout++;
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(nout), 32'd8);
        check("bp_sent", 32'(idx), 32'd8);
        check("bp_blocked", 32'(saw_block), 32'h1);

        // Full throughput: 4 words back-to-back, out_ready always high.
        idx = 0; nout = 0;
        for (int k = 0; k < 4; k++) begin
            in_cyc[k] = -100; out_cyc[k] = -200; tp_data[k] = 'x;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid = (idx < 4);
            in_data  = (idx < 4) ? bp_word[idx] : 32'h0;
            #1;
            if (out_valid && nout < 4) begin
                out_cyc[nout] = cyc;
                tp_data[nout] = out_data;
                nout++;
            end
            if (in_valid && in_ready) begin
                in_cyc[idx] = cyc;
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("tp_lat", 32'(out_cyc[k] - in_cyc[k]), 32'd3);
            check("tp_data", 32'(tp_data[k]), 32'(bp_exp[k]));
        end
        check("tp_rate", 32'(in_cyc[3] - in_cyc[0]), 32'd3);

        // Reset with three words in flight.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = bp_word[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mid_pre_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_drop_valid", 32'(out_valid), 32'h0);
        check("mid_drop_data", 32'(out_data), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            stale = stale | out_valid;
        end
        check("mid_no_stale", 32'(stale), 32'h0);
        convert(32'h40000000, 1'b0);
        check("mid_next_lat", 32'(r_lat), 32'd3);
        check("mid_next_data", 32'(r_data), 32'h8040);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
